// File: rtl/hdc_pkg.sv
// Shared HDC definitions: class codes, readout FSM states, classifier width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdc_pkg;

  // Hypervector width used by the classifier; readers default to the same.
  localparam int HDC_DIMENSIONS = 10000;

  // Class codes carried on out_class.
  localparam logic CLASS_NS = 1'b0;
  localparam logic CLASS_S  = 1'b1;

  // Class hypervector readout sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } hv_rd_state_t;

endpackage

// File: rtl/class_hv_reader.sv
// Streams the ns and s class hypervectors out as WORD_WIDTH words, ns first.
// Latency: first word valid one cycle after start is sampled in IDLE.
// Backpressure: valid/ready; a word is held stable until out_ready accepts it.
module class_hv_reader
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = HDC_DIMENSIONS,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [DIMENSIONS-1:0] ns_hv,
  input  logic [DIMENSIONS-1:0] s_hv,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_class,
  output logic                  out_last,
  output logic                  done
);

  localparam int NUM_WORDS = (DIMENSIONS + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  // Number of real hypervector bits in the final word of a class.
  localparam int REM       = DIMENSIONS - (NUM_WORDS - 1) * WORD_WIDTH;
  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [WORD_WIDTH-1:0] LAST_MASK = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - REM);

  hv_rd_state_t            state, state_nxt;
  logic [2*DIMENSIONS-1:0] snap_sreg;
  logic [CNT_W-1:0]        word_cnt;
  logic                    cls;
  logic                    accept;
  logic                    at_last;

  assign accept  = out_valid & out_ready;
  assign at_last = (word_cnt == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and status/output decode from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_class = CLASS_NS;
    out_last  = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_class = cls;
        out_last  = at_last;
        // The final ns word would otherwise expose the low s_hv bits above REM.
        out_data  = at_last ? (snap_sreg[WORD_WIDTH-1:0] & LAST_MASK)
                            : snap_sreg[WORD_WIDTH-1:0];
        if (accept && at_last && (cls == CLASS_S)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot shift register, word counter and class tracking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      snap_sreg <= '0;
      word_cnt  <= '0;
      cls       <= CLASS_NS;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_sreg <= {s_hv, ns_hv};
            word_cnt  <= '0;
            cls       <= CLASS_NS;
          end
        end
        STREAM: begin
          if (accept) begin
            if (at_last) begin
              // Shift only the leftover ns bits so s_hv word 0 lands at bit 0.
              snap_sreg <= snap_sreg >> REM;
              word_cnt  <= '0;
              cls       <= CLASS_S;
            end else begin
              snap_sreg <= snap_sreg >> WORD_WIDTH;
              word_cnt  <= word_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          word_cnt <= '0;
          cls      <= CLASS_NS;
        end
      endcase
    end
  end

endmodule
